seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Output side of the front panel: main's result digits go out to the multiplexed 7-segment array.
//  main writes 5-bit glyph codes into a shadow bank, then requests a swap.
//  The block copies shadow to active only at a frame boundary, so the display never tears.
//  It time-multiplexes DIGITS digits with a blanking slot per digit (anti-ghosting) and per-digit blink.
// PARAMETERS
//  DIGITS       8   digits scanned; index width AW = $clog2(DIGITS)
//  BIGN         50000  clocks per scan tick (BIGN=1 in simulation)
//  DRIVE_TICKS  3   ticks a digit is lit after its 1-tick blank slot
//  BLINK_FRAMES 64  full frames per blink half-period
// PORTS
//  clock      in   1      system clock; all logic on posedge
//  rst_n      in   1      synchronous active-low reset
//  wr_en      in   1      write shadow[wr_addr] this cycle
//  wr_addr    in   AW     digit index, 0 = rightmost
//  wr_data    in   5      glyph code
//  wr_dp      in   1      decimal point for that digit
//  wr_blink   in   1      blink enable for that digit
//  swap_req   in   1      request shadow->active copy (pulse or level)
//  swap_busy  out  1      swap requested, not yet applied
//  swap_done  out  1      1-cycle pulse on the cycle the copy happens
//  an_n       out  DIGITS anode enables, active low
//  seg_n      out  7      {g,f,e,d,c,b,a}, active low
//  dp_n       out  1      decimal point, active low
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - shadow and active glyphs = 16 (blank); dp=0; blink=0
//   - an_n all 1, seg_n=7'h7F, dp_n=1
//   - divider=0, digit=0, state=BLANK, frame count=0, blink phase=0
//   - swap_busy=0, swap_done=0
//   - Reset mid-frame aborts the scan and discards a pending swap.
//  Tick: divider counts 0..BIGN-1; tick=1 in the cycle divider==BIGN-1, then divider wraps to 0.
//  FSM (advances only on tick):
//   - BLANK: an_n all 1. After 1 tick -> DRIVE.
//   - DRIVE: an_n[digit]=0. After DRIVE_TICKS ticks -> BLANK with digit+1;
//     DIGITS-1 wraps to 0 (end of frame).
//  Outputs are registered: an_n/seg_n/dp_n change 1 clock after the state/digit change.
//  Glyph decode (seg_n): 0-15 -> hex 0-9, A, b, C, d, E, F; 16 blank; 17 '-' (7'h3F);
//   18 'P'; 19 'r'; 20 'o'; 21 'H'; 22-31 blank. '0'=7'h40, '1'=7'h79, '8'=7'h00.
//  dp_n = ~dp[digit] while DRIVE and digit is visible, else 1.
//  Blink:
//   - At each frame wrap, frame count increments; at BLINK_FRAMES-1 it wraps and blink phase toggles.
//   - A digit with blink=1 is forced blank (seg_n=7'h7F, dp_n=1) while blink phase=1.
//   - Its anode still strobes.
//  Writes: wr_en always accepted, 1 cycle; only the shadow bank is updated. wr_addr>=DIGITS is ignored.
//  Swap:
//   - swap_req=1 sets swap_busy on the next clock.
//   - Copy happens in the cycle the FSM enters BLANK for digit 0 (frame wrap);
//     swap_done=1 and swap_busy=0 on that same edge.
//   - swap_req during busy is absorbed (single swap).
//   - A write in the copy cycle lands in shadow only; active gets the pre-edge shadow value.
//   - swap_req asserted in the copy cycle itself re-arms swap_busy for the next frame.
//  Active bank is never written directly; power-up display is blank until the first swap.
// TESTING
//  1. Reset with BIGN=1, DRIVE_TICKS=3 -> an_n=8'hFF, seg_n=7'h7F; after release, first strobe an_n=8'hFE
//     lasts 3 clocks, separated by 1 blank clock.
//  2. Write codes 0..7 to digits 0..7, swap_req pulse -> swap_done exactly once at next frame wrap;
//     digit 0 then shows 7'h40, digit 1 shows 7'h79.
//  3. Write digit 3 = 8 with no swap -> display is unchanged for 5 frames; swap -> digit 3 seg_n=7'h00.
//  4. Digit 2 blink=1, BLINK_FRAMES=2 -> digit 2 blank in frames 2-3, visible in frames 4-5;
//     other digits are never blanked.
//  5. Assert rst_n=0 mid-DRIVE of digit 5 with swap pending -> next cycle an_n=8'hFF, swap_busy=0;
//     no swap_done follows.
//  6. Write + swap_req in the copy cycle -> active keeps the old value; swap_busy=1;
//     new value appears after the next frame wrap.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with a double-buffered glyph bank, a blanking
// slot ahead of every digit, per-digit blink, and tear-free shadow->active swap at frame wrap.
module seg_scan_driver #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned BIGN         = 50000,
    parameter int unsigned DRIVE_TICKS  = 3,
    parameter int unsigned BLINK_FRAMES = 64,
    localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_data,
    input  logic              wr_dp,
    input  logic              wr_blink,
    input  logic              swap_req,
    output logic              swap_busy,
    output logic              swap_done,
    output logic [DIGITS-1:0] an_n,
    output logic [6:0]        seg_n,
    output logic              dp_n
);

    localparam int unsigned DW = (BIGN > 1) ? $clog2(BIGN) : 1;
    localparam int unsigned TW = (DRIVE_TICKS > 1) ? $clog2(DRIVE_TICKS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [4:0] GLYPH_BLANK = 5'd16;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // Glyph code to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode_glyph(input logic [4:0] code);
        logic [6:0] segs;
        case (code)
            5'd0:    segs = 7'h40;
            5'd1:    segs = 7'h79;
            5'd2:    segs = 7'h24;
            5'd3:    segs = 7'h30;
            5'd4:    segs = 7'h19;
            5'd5:    segs = 7'h12;
            5'd6:    segs = 7'h02;
            5'd7:    segs = 7'h78;
            5'd8:    segs = 7'h00;
            5'd9:    segs = 7'h10;
            5'd10:   segs = 7'h08;
            5'd11:   segs = 7'h03;
            5'd12:   segs = 7'h46;
            5'd13:   segs = 7'h21;
            5'd14:   segs = 7'h06;
            5'd15:   segs = 7'h0E;
            5'd17:   segs = 7'h3F;
            5'd18:   segs = 7'h0C;
            5'd19:   segs = 7'h2F;
            5'd20:   segs = 7'h23;
            5'd21:   segs = 7'h09;
            default: segs = 7'h7F;
        endcase
        return segs;
    endfunction

    // Glyph banks
    logic [4:0]        sh_glyph [DIGITS];
    logic [DIGITS-1:0] sh_dp;
    logic [DIGITS-1:0] sh_blink;
    logic [4:0]        ac_glyph [DIGITS];
    logic [DIGITS-1:0] ac_dp;
    logic [DIGITS-1:0] ac_blink;

    // Scan control
    logic [DW-1:0]     div_q, div_d;
    logic [0:0]        state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [AW-1:0]     digit_q, digit_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              phase_q, phase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic tick;
    logic frame_wrap;
    logic do_copy;
    logic wr_ok;
    logic hidden;

    assign tick    = (div_q == DW'(BIGN - 1));
    assign wr_ok   = wr_en && (32'(wr_addr) < DIGITS);
    assign do_copy = frame_wrap && busy_q;

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Blank slot of one tick, then DRIVE_TICKS ticks of drive, per digit.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        digit_d    = digit_q;
        frame_wrap = 1'b0;
        if (tick) begin
            case (state_q)
                ST_BLANK: begin
                    state_d = ST_DRIVE;
                    tcnt_d  = '0;
                end
                default: begin
                    if (tcnt_q == TW'(DRIVE_TICKS - 1)) begin
                        state_d = ST_BLANK;
                        tcnt_d  = '0;
                        if (digit_q == AW'(DIGITS - 1)) begin
                            digit_d    = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // A request in the copy cycle itself re-arms for the following frame.
    always_comb begin
        busy_d = swap_req || (busy_q && !do_copy);
        done_d = do_copy;
    end

    // Output stage works off the current state; the result is registered.
    always_comb begin
        an_d   = '1;
        seg_d  = 7'h7F;
        dp_d   = 1'b1;
        hidden = ac_blink[digit_q] && phase_q;
        if (state_q == ST_DRIVE) begin
            an_d[digit_q] = 1'b0;
            if (!hidden) begin
                seg_d = decode_glyph(ac_glyph[digit_q]);
                dp_d  = ~ac_dp[digit_q];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                sh_glyph[i] <= GLYPH_BLANK;
            end
            sh_dp    <= '0;
            sh_blink <= '0;
        end else if (wr_ok) begin
            sh_glyph[wr_addr] <= wr_data;
            sh_dp[wr_addr]    <= wr_dp;
            sh_blink[wr_addr] <= wr_blink;
        end
    end

    // Active bank only ever receives the pre-edge shadow contents.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                ac_glyph[i] <= GLYPH_BLANK;
            end
            ac_dp    <= '0;
            ac_blink <= '0;
        end else if (do_copy) begin
            ac_glyph <= sh_glyph;
            ac_dp    <= sh_dp;
            ac_blink <= sh_blink;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            div_q   <= '0;
            state_q <= ST_BLANK;
            tcnt_q  <= '0;
            digit_q <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            digit_q <= digit_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign swap_busy = busy_q;
    assign swap_done = done_q;
    assign an_n      = an_q;
    assign seg_n     = seg_q;
    assign dp_n      = dp_q;

endmodule
